// File: rtl/myproject_acc_pkg.sv
// Package shared by the accumulate/requantize stage.
// Holds the product and activation widths, the activation full-scale value,
// and a helper that returns the smallest accumulator width able to hold a
// full frame plus bias without wrapping.
package myproject_acc_pkg;

  localparam int PROD_W = 30;
  localparam int OUT_W  = 16;
  localparam logic [OUT_W-1:0] OUT_MAX = 16'hFFFF;

  // A frame sums n_in products of PROD_W bits. clog2(n_in) bits of growth
  // are needed for that sum, plus one more bit so the bias cannot overflow.
  function automatic int min_acc_w(input int n_in);
    int growth;
    growth = (n_in > 1) ? $clog2(n_in) : 0;
    return PROD_W + growth + 1;
  endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational requantizer: round-half-up right shift by SHIFT, then
// saturate to an unsigned 16-bit activation.
// Ports:
//   sum : ACC_W-bit unsigned frame sum
//   q   : 16-bit unsigned requantized result
//   sat : high when the rounded value exceeded the 16-bit range
module myproject_round_sat
  import myproject_acc_pkg::*;
#(
  parameter int ACC_W = 34,
  parameter int SHIFT = 10
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] q,
  output logic             sat
);

  // Half an output LSB. With SHIFT=0 there is nothing to round.
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;

  // One extra bit of headroom so adding the rounding constant never wraps.
  function automatic logic [ACC_W:0] round_half_up(input logic [ACC_W-1:0] x);
    logic [ACC_W:0] ext;
    ext = {1'b0, x} + RND;
    return ext >> SHIFT;
  endfunction

  function automatic logic is_sat(input logic [ACC_W:0] r);
    return |r[ACC_W:OUT_W];
  endfunction

  function automatic logic [OUT_W-1:0] sat_val(input logic [ACC_W:0] r);
    return is_sat(r) ? OUT_MAX : r[OUT_W-1:0];
  endfunction

  logic [ACC_W:0] w_rnd;

  always_comb begin
    w_rnd = round_half_up(sum);
    q     = sat_val(w_rnd);
    sat   = is_sat(w_rnd);
  end

endmodule

// File: rtl/myproject_acc_requant_30u_16u.sv
// Frame accumulator + requantizer for the unsigned dense-layer datapath.
// Sums N_IN 30-bit products per frame, adds BIAS, rounds/saturates the sum
// to a 16-bit activation and presents it on a valid/ready output register.
// Ports:
//   ap_clk, ap_rst         : clock (rising edge), async active-high reset
//   in_data/in_valid/in_ready    : product input handshake
//   out_data/out_valid/out_ready : result output handshake
//   sat_clr    : synchronous clear of sat_sticky (a new saturation wins)
//   sat_sticky : a result saturated since the last clear or reset
module myproject_acc_requant_30u_16u
  import myproject_acc_pkg::*;
#(
  parameter int               N_IN  = 8,
  parameter int               ACC_W = 34,
  parameter int               SHIFT = 10,
  parameter logic [ACC_W-1:0] BIAS  = '0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              sat_clr,
  output logic              sat_sticky
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  generate
    if (N_IN < 1) begin : g_bad_n_in
      $error("N_IN must be at least 1");
    end
    if (ACC_W < min_acc_w(N_IN)) begin : g_bad_acc_w
      $error("ACC_W too narrow for N_IN products plus bias");
    end
    if (SHIFT < 0 || SHIFT > ACC_W - OUT_W) begin : g_bad_shift
      $error("SHIFT out of range 0..ACC_W-16");
    end
  endgenerate

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_out_data_p1;
  logic             r_out_valid_p1;
  logic             r_sat_sticky;

  logic             w_final;
  logic             w_accept;
  logic [ACC_W-1:0] w_sum_p0;
  logic [OUT_W-1:0] w_q_p0;
  logic             w_sat_p0;

  // Stage p0: accumulate the incoming beat and requantize on the final beat.
  always_comb begin
    w_final  = (r_cnt == CNT_LAST);
    // Only the final beat needs a free output slot; earlier beats of the
    // next frame keep flowing while a result waits.
    in_ready = !(w_final && r_out_valid_p1 && !out_ready);
    w_accept = in_valid && in_ready;
    w_sum_p0 = r_acc + {{(ACC_W-PROD_W){1'b0}}, in_data};
  end

  myproject_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .sum (w_sum_p0),
    .q   (w_q_p0),
    .sat (w_sat_p0)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc <= BIAS;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_final) begin
        r_acc <= BIAS;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum_p0;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Stage p1: output register. A final beat accepted in the same cycle as a
  // handoff reloads the register so results stream without a bubble.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_valid_p1 <= 1'b0;
      r_out_data_p1  <= '0;
      r_sat_sticky   <= 1'b0;
    end else begin
      if (w_accept && w_final) begin
        r_out_valid_p1 <= 1'b1;
        r_out_data_p1  <= w_q_p0;
      end else if (out_ready) begin
        r_out_valid_p1 <= 1'b0;
      end

      if (w_accept && w_final && w_sat_p0) begin
        r_sat_sticky <= 1'b1;
      end else if (sat_clr) begin
        r_sat_sticky <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data_p1;
  assign out_valid  = r_out_valid_p1;
  assign sat_sticky = r_sat_sticky;

endmodule

// File: tb/tb_myproject_acc_requant_30u_16u.sv
module tb_myproject_acc_requant_30u_16u;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // DUT A: N_IN=4, SHIFT=10, BIAS=0
  logic [29:0] a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [15:0] a_out_data;
  logic        a_out_valid, a_out_ready;
  logic        a_sat_clr, a_sat_sticky;

  // DUT B: N_IN=1, SHIFT=0, BIAS=2048
  logic [29:0] b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [15:0] b_out_data;
  logic        b_out_valid, b_out_ready;
  logic        b_sat_clr, b_sat_sticky;

  myproject_acc_requant_30u_16u #(
    .N_IN(4), .ACC_W(34), .SHIFT(10), .BIAS(34'd0)
  ) u_dut_a (
    .ap_clk(clk), .ap_rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sat_clr(a_sat_clr), .sat_sticky(a_sat_sticky)
  );

  myproject_acc_requant_30u_16u #(
    .N_IN(1), .ACC_W(34), .SHIFT(0), .BIAS(34'd2048)
  ) u_dut_b (
    .ap_clk(clk), .ap_rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sat_clr(b_sat_clr), .sat_sticky(b_sat_sticky)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  localparam logic [29:0] PMAX = 30'h3FFF_FFFF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: every handshake seen pops one expected result.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_out", 32'(a_out_data), 32'hFFFF_FFFF);
      else chk("a_out_data", 32'(a_out_data), 32'(q_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_out", 32'(b_out_data), 32'hFFFF_FFFF);
      else chk("b_out_data", 32'(b_out_data), 32'(q_b.pop_front()));
    end
  end

  task automatic send_a(input logic [29:0] d);
    bit ok;
    ok = 0;
    a_in_data  = d;
    a_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("a_accept_timeout", 32'(a_in_ready), 32'd1);
    else @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_in_data  = '0;
  endtask

  task automatic send_b(input logic [29:0] d);
    bit ok;
    ok = 0;
    b_in_data  = d;
    b_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("b_accept_timeout", 32'(b_in_ready), 32'd1);
    else @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_data  = '0;
  endtask

  task automatic frame_a(input logic [29:0] d0, d1, d2, d3,
                         input bit push, input logic [15:0] exp);
    send_a(d0);
    send_a(d1);
    send_a(d2);
    if (push) q_a.push_back(exp);
    send_a(d3);
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_sat_clr = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_sat_clr = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_sat_sticky", 32'(a_sat_sticky), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;

    // 1: basic frame, one-cycle latency
    send_a(30'd1024); send_a(30'd1024); send_a(30'd1024);
    chk("t1_no_early_valid", 32'(a_out_valid), 32'd0);
    q_a.push_back(16'd4);
    send_a(30'd1024);
    @(negedge clk);
    chk("t1_valid", 32'(a_out_valid), 32'd1);
    chk("t1_data", 32'(a_out_data), 32'd4);
    chk("t1_sticky", 32'(a_sat_sticky), 32'd0);
    @(posedge clk); #1;

    // 2: rounding half-up boundary
    frame_a(30'd512, 30'd0, 30'd0, 30'd0, 1, 16'd1);
    frame_a(30'd511, 30'd0, 30'd0, 30'd0, 1, 16'd0);
    @(negedge clk);
    chk("t2_round_down", 32'(a_out_data), 32'd0);
    @(posedge clk); #1;

    // 3: saturation, sticky clear, set-over-clear
    frame_a(PMAX, PMAX, PMAX, PMAX, 1, 16'hFFFF);
    @(negedge clk);
    chk("t3_sat_data", 32'(a_out_data), 32'd65535);
    chk("t3_sticky_set", 32'(a_sat_sticky), 32'd1);
    @(posedge clk); #1;
    a_sat_clr = 1'b1;
    @(posedge clk); #1;
    a_sat_clr = 1'b0;
    @(negedge clk);
    chk("t3_sticky_clr", 32'(a_sat_sticky), 32'd0);
    @(posedge clk); #1;
    send_a(PMAX); send_a(PMAX); send_a(PMAX);
    q_a.push_back(16'hFFFF);
    a_sat_clr = 1'b1;
    send_a(PMAX);
    a_sat_clr = 1'b0;
    @(negedge clk);
    chk("t3_set_wins", 32'(a_sat_sticky), 32'd1);
    @(posedge clk); #1;

    // 4: backpressure, final beat stalls, no bubble on release
    a_out_ready = 1'b0;
    frame_a(30'd1024, 30'd1024, 30'd1024, 30'd1024, 1, 16'd4);
    @(negedge clk);
    chk("t4_pending_valid", 32'(a_out_valid), 32'd1);
    @(posedge clk); #1;
    send_a(30'd2048); send_a(30'd2048); send_a(30'd2048);
    q_a.push_back(16'd8);
    a_in_data  = 30'd2048;
    a_in_valid = 1'b1;
    @(negedge clk);
    chk("t4_stall_ready", 32'(a_in_ready), 32'd0);
    chk("t4_hold_data", 32'(a_out_data), 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_stall_ready2", 32'(a_in_ready), 32'd0);
    chk("t4_hold_data2", 32'(a_out_data), 32'd4);
    chk("t4_hold_valid2", 32'(a_out_valid), 32'd1);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data  = '0;
    @(negedge clk);
    chk("t4_no_bubble_valid", 32'(a_out_valid), 32'd1);
    chk("t4_frame2_data", 32'(a_out_data), 32'd8);
    @(posedge clk); #1;

    // 5: async reset mid-frame with a pending result
    a_out_ready = 1'b0;
    frame_a(30'd1024, 30'd1024, 30'd1024, 30'd1024, 0, 16'd0);
    send_a(30'd5000); send_a(30'd7000);
    chk("t5_pending_before_rst", 32'(a_out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(a_out_valid), 32'd0);
    chk("t5_rst_data", 32'(a_out_data), 32'd0);
    chk("t5_rst_sticky", 32'(a_sat_sticky), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    frame_a(30'd1024, 30'd1024, 30'd1024, 30'd1024, 1, 16'd4);
    @(negedge clk);
    chk("t5_no_residue", 32'(a_out_data), 32'd4);
    @(posedge clk); #1;

    // 6: N_IN=1, SHIFT=0, BIAS=2048
    q_b.push_back(16'hFFFF);
    send_b(30'd65000);
    @(negedge clk);
    chk("t6_sat_valid", 32'(b_out_valid), 32'd1);
    chk("t6_sat_data", 32'(b_out_data), 32'd65535);
    chk("t6_sticky", 32'(b_sat_sticky), 32'd1);
    @(posedge clk); #1;
    q_b.push_back(16'd2048);
    send_b(30'd0);
    @(negedge clk);
    chk("t6_bias_only", 32'(b_out_data), 32'd2048);
    @(posedge clk); #1;

    // Drain scoreboards
    for (int i = 0; i < 20; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(posedge clk);
    end
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
